// File: rtl/ymem_loader_pkg.sv
// Shared definitions for the program loader: FSM states, default frame header
// and the byte-lane positions used when assembling little-endian words.
package yloader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        COUNT,
        DATA,
        CSUM,
        START,
        ERROR
    } loaderState_t;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    localparam logic [1:0] LANE_FIRST = 2'd0;
    localparam logic [1:0] LANE_LAST  = 2'd3;

endpackage

// File: rtl/ymem_loader_yword_asm.sv
// Collects four strobed bytes into a little-endian 32-bit word; the complete
// word is presented combinationally in the same cycle as the fourth byte.
module yword_asm
    import yloader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  dataByte,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  lane;
    logic [23:0] partial;

    // The oldest byte ends up in the low lane, so shifting in from the top
    // leaves bytes 0..2 in place when byte 3 arrives.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            lane    <= LANE_FIRST;
            partial <= '0;
        end else if (strobe) begin
            lane    <= lane + 2'd1;
            partial <= {dataByte, partial[23:8]};
        end
    end

    assign word      = {dataByte, partial};
    assign word_done = strobe && (lane == LANE_LAST);

endmodule

// File: rtl/ymem_loader.sv
// Framed byte-stream program loader: writes instruction words into imem and
// starts the CPU with entryPoint plus a one-cycle INT pulse.
module ymem_loader
    import yloader_pkg::*;
#(
    parameter int         MAX_WORDS = 1024,
    parameter logic [7:0] HDR       = HDR_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic [31:0] entryPoint,
    output logic        INT,
    output logic        busy,
    output logic        err
);

    loaderState_t state, nextState;

    logic        outOfReset;
    logic        xfer;
    logic        frameStart;
    logic [7:0]  xorAcc;
    logic        countPhase;
    logic [7:0]  countLo;
    logic [15:0] countValue;
    logic [15:0] wordCount;
    logic [15:0] wordIdx;
    logic        asmStrobe;
    logic        asmClear;
    logic        wordDone;
    logic [31:0] asmWord;

    assign in_ready   = outOfReset && (state != START);
    assign xfer       = in_valid && in_ready;
    assign countValue = {in_byte, countLo};
    assign INT        = (state == START);
    assign busy       = (state == ENTRY) || (state == COUNT) ||
                        (state == DATA)  || (state == CSUM);

    yword_asm wordAsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .dataByte  (in_byte),
        .strobe    (asmStrobe),
        .clear     (asmClear),
        .word      (asmWord),
        .word_done (wordDone)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ERROR behaves like IDLE for an arriving byte so a header right after a
    // rejected frame is not lost.
    always_comb begin
        nextState  = state;
        asmStrobe  = 1'b0;
        asmClear   = 1'b0;
        frameStart = 1'b0;
        case (state)
            IDLE, ERROR: begin
                nextState = IDLE;
                if (xfer && (in_byte == HDR)) begin
                    nextState  = ENTRY;
                    frameStart = 1'b1;
                    asmClear   = 1'b1;
                end
            end
            ENTRY: begin
                asmStrobe = xfer;
                if (wordDone) begin
                    nextState = COUNT;
                end
            end
            COUNT: begin
                if (xfer && countPhase) begin
                    if ({16'd0, countValue} > 32'(MAX_WORDS)) begin
                        nextState = ERROR;
                    end else if (countValue == 16'd0) begin
                        nextState = CSUM;
                    end else begin
                        nextState = DATA;
                    end
                end
            end
            DATA: begin
                asmStrobe = xfer;
                if (wordDone && (wordIdx == wordCount - 16'd1)) begin
                    nextState = CSUM;
                end
            end
            CSUM: begin
                if (xfer) begin
                    nextState = (in_byte == xorAcc) ? START : ERROR;
                end
            end
            START: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outOfReset <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            entryPoint <= '0;
            err        <= 1'b0;
            xorAcc     <= '0;
            countPhase <= 1'b0;
            countLo    <= '0;
            wordCount  <= '0;
            wordIdx    <= '0;
        end else begin
            outOfReset <= 1'b1;
            imem_we    <= 1'b0;

            if (frameStart) begin
                err        <= 1'b0;
                xorAcc     <= '0;
                countPhase <= 1'b0;
                wordIdx    <= '0;
            end

            if (nextState == ERROR) begin
                err <= 1'b1;
            end

            if (xfer && ((state == ENTRY) || (state == COUNT) || (state == DATA))) begin
                xorAcc <= xorAcc ^ in_byte;
            end

            if ((state == ENTRY) && wordDone) begin
                entryPoint <= asmWord;
            end

            if ((state == COUNT) && xfer) begin
                if (!countPhase) begin
                    countLo    <= in_byte;
                    countPhase <= 1'b1;
                end else begin
                    wordCount  <= countValue;
                    countPhase <= 1'b0;
                end
            end

            // Word index is scaled to a byte offset; the add wraps at 2^32.
            if ((state == DATA) && wordDone) begin
                imem_we    <= 1'b1;
                imem_addr  <= entryPoint + {14'd0, wordIdx, 2'b00};
                imem_wdata <= asmWord;
                wordIdx    <= wordIdx + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ymem_loader.sv
// Self-checking bench for ymem_loader: directed and random frames compared
// against a frame-level model of the expected writes, start pulse and error flag.
module tb_ymem_loader;

    localparam int         MAX_WORDS = 1024;
    localparam logic [7:0] HDR       = 8'hA5;

    logic        clk;
    logic        rstN;
    logic [7:0]  inByte;
    logic        inValid;
    logic        inReady;
    logic        imemWe;
    logic [31:0] imemAddr;
    logic [31:0] imemWdata;
    logic [31:0] entryPoint;
    logic        intPulse;
    logic        busy;
    logic        err;

    int checkCount = 0;
    int passCount  = 0;

    logic [63:0] obsWrites[$];
    logic [31:0] obsInts[$];
    logic [31:0] frameWords[$];

    ymem_loader #(
        .MAX_WORDS (MAX_WORDS),
        .HDR       (HDR)
    ) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .in_byte    (inByte),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .imem_we    (imemWe),
        .imem_addr  (imemAddr),
        .imem_wdata (imemWdata),
        .entryPoint (entryPoint),
        .INT        (intPulse),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imemWe) obsWrites.push_back({imemAddr, imemWdata});
        if (intPulse) obsInts.push_back(entryPoint);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        inValid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Starts and ends on a falling edge; the byte moves on the rising edge
    // at which inReady is high.
    task automatic sendByte(input logic [7:0] b);
        int waitCnt;
        waitCnt = 0;
        inValid = 1'b1;
        inByte  = b;
        while (!inReady && waitCnt < 16) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!inReady) begin
            checkOutput("ready_timeout", 64'(inReady), 64'd1);
            inValid = 1'b0;
            return;
        end
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] entry, input int n, input bit badCsum,
                                 input int gapMode, input bit garbage);
        logic [7:0]  payload[$];
        logic [63:0] expWrites[$];
        logic [7:0]  csum;
        logic [31:0] addr;
        logic [15:0] n16;
        bit          oversize;
        bit          expInt;
        int          numChecked;

        n16      = 16'(n);
        oversize = (n > MAX_WORDS);
        for (int b = 0; b < 4; b++) payload.push_back(entry[8*b +: 8]);
        payload.push_back(n16[7:0]);
        payload.push_back(n16[15:8]);
        if (!oversize) begin
            for (int i = 0; i < n; i++) begin
                for (int b = 0; b < 4; b++) payload.push_back(frameWords[i][8*b +: 8]);
                addr = entry + 32'(i * 4);
                expWrites.push_back({addr, frameWords[i]});
            end
        end
        csum = 8'h00;
        foreach (payload[i]) csum = csum ^ payload[i];
        if (badCsum) csum = csum ^ 8'h01;
        expInt = !oversize && !badCsum;

        obsWrites.delete();
        obsInts.delete();

        if (garbage) begin
            sendByte(8'h00);
            sendByte(8'hFF);
        end
        sendByte(HDR);
        checkOutput("busy_after_hdr", 64'(busy), 64'd1);

        foreach (payload[p]) begin
            if (gapMode == 1 && p >= 7) idleCycles(3);
            if (gapMode == 2) idleCycles($urandom_range(0, 2));
            sendByte(payload[p]);
            if (p >= 6) begin
                checkOutput("we_timing", 64'(imemWe), 64'(((p - 6) % 4) == 3));
            end
            if (p == 5 && oversize) begin
                checkOutput("err_oversize", 64'(err), 64'd1);
                checkOutput("busy_oversize", 64'(busy), 64'd0);
            end
        end

        if (!oversize) begin
            sendByte(csum);
            checkOutput("int_after_csum", 64'(intPulse), 64'(expInt));
            checkOutput("busy_after_csum", 64'(busy), 64'd0);
            checkOutput("ready_after_csum", 64'(inReady), 64'(!expInt));
        end
        idleCycles(3);

        checkOutput("write_count", 64'(obsWrites.size()), 64'(expWrites.size()));
        numChecked = (obsWrites.size() < expWrites.size()) ? obsWrites.size() : expWrites.size();
        for (int i = 0; i < numChecked; i++) begin
            checkOutput("write_addr_data", obsWrites[i], expWrites[i]);
        end
        checkOutput("int_count", 64'(obsInts.size()), 64'(expInt));
        if (expInt && obsInts.size() > 0) begin
            checkOutput("int_entry", 64'(obsInts[0]), 64'(entry));
        end
        checkOutput("err_sticky", 64'(err), 64'(!expInt));
        checkOutput("entry_point", 64'(entryPoint), 64'(entry));
        checkOutput("ready_idle", 64'(inReady), 64'd1);
    endtask

    task automatic checkResetOutputs(input string phase);
        checkOutput({phase, "_we"},    64'(imemWe),     64'd0);
        checkOutput({phase, "_addr"},  64'(imemAddr),   64'd0);
        checkOutput({phase, "_wdata"}, 64'(imemWdata),  64'd0);
        checkOutput({phase, "_entry"}, 64'(entryPoint), 64'd0);
        checkOutput({phase, "_int"},   64'(intPulse),   64'd0);
        checkOutput({phase, "_busy"},  64'(busy),       64'd0);
        checkOutput({phase, "_err"},   64'(err),        64'd0);
        checkOutput({phase, "_ready"}, 64'(inReady),    64'd0);
    endtask

    initial begin
        logic [31:0] entry;
        int          n;

        rstN    = 1'b0;
        inValid = 1'b0;
        inByte  = 8'h00;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(inReady), 64'd1);

        frameWords = '{32'h00500093, 32'h00A08133};
        applyStimulus(32'h28, 2, 1'b0, 0, 1'b0);
        applyStimulus(32'h28, 2, 1'b1, 0, 1'b0);

        frameWords.delete();
        applyStimulus(32'h100, 0, 1'b0, 0, 1'b0);

        frameWords = '{32'h00500093, 32'h00A08133};
        applyStimulus(32'h28, 2, 1'b0, 1, 1'b1);

        frameWords.delete();
        applyStimulus(32'h40, MAX_WORDS + 1, 1'b0, 0, 1'b0);

        // Abort a frame after two bytes of its first word.
        sendByte(HDR);
        sendByte(8'h00); sendByte(8'h02); sendByte(8'h00); sendByte(8'h00);
        sendByte(8'h02); sendByte(8'h00);
        sendByte(8'h93); sendByte(8'h00);
        obsWrites.delete();
        rstN = 1'b0;
        @(negedge clk);
        checkResetOutputs("mid_data_reset");
        rstN = 1'b1;
        idleCycles(2);
        checkOutput("mid_data_no_write", 64'(obsWrites.size()), 64'd0);
        checkOutput("mid_data_ready", 64'(inReady), 64'd1);
        frameWords = '{32'h00500093, 32'h00A08133};
        applyStimulus(32'h28, 2, 1'b0, 0, 1'b0);

        frameWords = '{32'hA5A5A5A5, 32'h000000A5, 32'h11223344, 32'hDEADBEEF};
        applyStimulus(32'hFFFF_FFF8, 4, 1'b0, 0, 1'b0);

        frameWords.delete();
        for (int i = 0; i < MAX_WORDS; i++) frameWords.push_back($urandom);
        applyStimulus(32'h0000_1000, MAX_WORDS, 1'b0, 0, 1'b0);

        for (int f = 0; f < 12; f++) begin
            entry = $urandom & 32'hFFFF_FFFC;
            n     = $urandom_range(0, 5);
            if ($urandom_range(0, 5) == 0) n = MAX_WORDS + 1 + $urandom_range(0, 200);
            frameWords.delete();
            if (n <= MAX_WORDS) begin
                for (int i = 0; i < n; i++) frameWords.push_back($urandom);
            end
            applyStimulus(entry, n, ($urandom_range(0, 3) == 0), 2, bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
